note_slot_allocator: RTL and testbench
======================================

# note_slot_allocator

Controller for the 37-slot note buffer that feeds the buffer serializer. Accepts chart notes from the song reader and assigns each to a free slot with a one-hot load strobe. Frees a slot when the slot reports a match, or when the note expires unplayed; an expired note produces a single miss event. A round-robin expiry scanner sweeps the slots, so each slot is time-shared between successive notes without software involvement.

## Interface
Parameters:
- NUM_SLOTS, 37, number of note slots; sets widths of the slot vectors.
- TIME_W, 16, width of song_time and of note timestamps.
- MISS_WINDOW, 8, late tolerance in song_time ticks before an unmatched note is declared missed.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- song_time  in  16  current song position; free-running, wraps modulo 2^16.
- note_valid  in  1  the song reader presents a note.
- note_ready  out  1  a slot is free; a note is accepted on the cycle where note_valid && note_ready.
- note_time  in  16  target time of the presented note.
- note_fret  in  5  fret mask of the presented note.
- match_trigger  in  37  per-slot match pulse from the slot bank; bit i retires slot i.
- slot_load  out  37  one-hot, single-cycle load strobe for the chosen slot.
- slot_time  out  16  time to load; valid with slot_load.
- slot_fret  out  5  fret mask to load; valid with slot_load.
- slot_busy  out  37  occupancy vector; bit i is high while slot i holds a live note.
- miss_en  out  1  single-cycle pulse reporting an expired note.
- miss_slot  out  6  index of the expired slot; valid with miss_en.
- miss_time  out  16  stored target time of the expired note; valid with miss_en.
- free_count  out  6  number of free slots, registered.

## Operation
- State per slot: a busy bit and a stored 16-bit target time. Internal state also holds a 6-bit scan pointer.
- note_ready is combinational: it equals rst_n && (slot_busy != all-ones).
- **Allocation**
  - On an accepted note, the lowest-index slot with busy=0 in the current cycle is chosen.
  - Next edge: that busy bit sets, the time is stored, and slot_load/slot_time/slot_fret are registered.
  - At most one note is allocated per cycle.
- **Match retire**
  - If match_trigger[i] && busy[i], busy[i] clears on the next edge.
  - A trigger on a non-busy slot is ignored.
  - Several triggers in one cycle retire all of their slots together.
- **Expiry scan**
  - Each cycle the scanner examines slot ptr. ptr increments and wraps from 36 to 0, regardless of outcome.
  - Slot ptr is expired when busy[ptr] is set, match_trigger[ptr] is low, and the signed 16-bit value of (song_time - stored_time[ptr]) is greater than MISS_WINDOW. The signed subtraction makes the test wrap-safe.
  - On expiry, next edge: busy[ptr] clears, miss_en=1, miss_slot=ptr, miss_time=stored_time[ptr].
- **Priorities**
  - A match beats a miss for the same slot in the same cycle: no miss is reported, and the slot retires as matched.
  - A slot freed in cycle N is not eligible for allocation until cycle N+1.
- **Arithmetic**
  - free_count = NUM_SLOTS − popcount(busy after the update). It is registered and coherent with slot_busy.
  - All time arithmetic is modulo 2^16; there is no saturation.

## Timing
- Reset values, all on the first edge with rst_n=0:
  - busy=0, ptr=0.
  - slot_load=0, slot_time=0, slot_fret=0, slot_busy=0.
  - miss_en=0, miss_slot=0, miss_time=0.
  - free_count=37.
- Reset mid-operation: every slot is freed silently, with no miss pulses.
- Allocation latency is 1 cycle, from the accept edge to slot_load. Sustained throughput is 1 note per cycle while slots are free.
- Match retire latency is 1 cycle, from match_trigger to the slot_busy bit falling.
- Worst-case miss latency is NUM_SLOTS cycles after the expiry condition first holds.
- Pulse widths: slot_load and miss_en are high for exactly one cycle per event.
- Full buffer: note_ready is low and note_valid is held upstream. Acceptance resumes the cycle after any slot frees.
- Empty buffer: the scanner keeps running and produces no miss events.

## Test plan
- Reset, then present 3 back-to-back notes (times 100, 101, 102) → slot_load = bit0, bit1, bit2 on consecutive cycles; free_count counts 37→34.
- Fill all 37 slots → note_ready falls. Pulse match_trigger[12] → the next held note loads slot 12 one cycle after busy[12] clears.
- Load slot 0 with time 7. Advance song_time to 15 → no miss. Advance to 16 → miss_en with miss_slot=0 and miss_time=7, within 37 cycles; busy[0] clears.
- Assert match_trigger[ptr] in the same cycle that slot ptr would expire → no miss_en; the slot frees as matched.
- Load a note with time 0xFFFC while song_time=0xFFF0. Let song_time wrap to 0x0003 → no miss. At 0x0005 → miss reported.
- Assert rst_n=0 for 1 cycle with 20 slots busy → slot_busy=0, free_count=37, miss_en stays 0.

Source files
------------

// File: rtl/note_slot_allocator.sv
// Note buffer slot controller: hands free slots to incoming chart notes, retires
// slots on match or expiry, and reports expired notes as single miss events.
module note_slot_cell #(
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set,
    input  logic              clr,
    input  logic [TIME_W-1:0] set_time,
    output logic              busy,
    output logic [TIME_W-1:0] tstamp
);
    always_ff @(posedge clk) begin
        if (!rst_n)   busy <= 1'b0;
        else if (set) busy <= 1'b1;
        else if (clr) busy <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (set) tstamp <= set_time;
    end
endmodule

module note_slot_allocator #(
    parameter  int NUM_SLOTS   = 37,
    parameter  int TIME_W      = 16,
    parameter  int MISS_WINDOW = 8,
    localparam int IDX_W       = $clog2(NUM_SLOTS),
    localparam int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_W-1:0]    song_time,
    input  logic                 note_valid,
    output logic                 note_ready,
    input  logic [TIME_W-1:0]    note_time,
    input  logic [4:0]           note_fret,
    input  logic [NUM_SLOTS-1:0] match_trigger,
    output logic [NUM_SLOTS-1:0] slot_load,
    output logic [TIME_W-1:0]    slot_time,
    output logic [4:0]           slot_fret,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 miss_en,
    output logic [IDX_W-1:0]     miss_slot,
    output logic [TIME_W-1:0]    miss_time,
    output logic [CNT_W-1:0]     free_count
);
    logic [NUM_SLOTS-1:0]             busy, alloc_oh, match_clr, expire_oh, busy_nxt;
    logic [NUM_SLOTS-1:0][TIME_W-1:0] tstamp;
    logic [IDX_W-1:0]                 ptr;
    logic [TIME_W-1:0]                age;
    logic                             accept, expire;

    assign note_ready = rst_n && (busy != '1);
    assign accept     = note_valid && note_ready;
    // Isolate the lowest clear bit of busy; chosen from pre-update occupancy,
    // so a slot retired this cycle only becomes eligible next cycle.
    assign alloc_oh   = accept ? (~busy & (busy + NUM_SLOTS'(1))) : '0;
    assign match_clr  = match_trigger & busy;

    // Signed difference keeps the lateness test correct across song_time wrap.
    assign age        = song_time - tstamp[ptr];
    assign expire     = busy[ptr] && !match_trigger[ptr] &&
                        ($signed(age) > $signed(TIME_W'(MISS_WINDOW)));
    assign expire_oh  = expire ? (NUM_SLOTS'(1) << ptr) : '0;
    assign busy_nxt   = (busy & ~match_clr & ~expire_oh) | alloc_oh;
    assign slot_busy  = busy;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        note_slot_cell #(.TIME_W(TIME_W)) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .set      (alloc_oh[i]),
            .clr      (match_clr[i] | expire_oh[i]),
            .set_time (note_time),
            .busy     (busy[i]),
            .tstamp   (tstamp[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            slot_load  <= '0;
            slot_time  <= '0;
            slot_fret  <= '0;
            miss_en    <= 1'b0;
            miss_slot  <= '0;
            miss_time  <= '0;
            free_count <= CNT_W'(NUM_SLOTS);
        end else begin
            ptr       <= (ptr == IDX_W'(NUM_SLOTS - 1)) ? '0 : ptr + IDX_W'(1);
            slot_load <= alloc_oh;
            if (accept) begin
                slot_time <= note_time;
                slot_fret <= note_fret;
            end
            miss_en <= expire;
            if (expire) begin
                miss_slot <= ptr;
                miss_time <= tstamp[ptr];
            end
            free_count <= CNT_W'(NUM_SLOTS - $countones(busy_nxt));
        end
    end
endmodule

// File: tb/tb_note_slot_allocator.sv
// Scoreboard bench for note_slot_allocator: directed scenarios plus randomized
// traffic, checked against a slot-level reference model.
module tb_note_slot_allocator;
    localparam int N = 37;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   song_time = '0;
    logic          note_valid = 1'b0;
    logic [15:0]   note_time = '0;
    logic [4:0]    note_fret = '0;
    logic [N-1:0]  match_trigger = '0;
    logic          note_ready;
    logic [N-1:0]  slot_load, slot_busy;
    logic [15:0]   slot_time, miss_time;
    logic [4:0]    slot_fret;
    logic          miss_en;
    logic [5:0]    miss_slot, free_count;

    always #5 clk = ~clk;

    note_slot_allocator dut (
        .clk(clk), .rst_n(rst_n), .song_time(song_time),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_time(note_time), .note_fret(note_fret),
        .match_trigger(match_trigger), .slot_load(slot_load),
        .slot_time(slot_time), .slot_fret(slot_fret), .slot_busy(slot_busy),
        .miss_en(miss_en), .miss_slot(miss_slot), .miss_time(miss_time),
        .free_count(free_count)
    );

    typedef struct { int idx; logic [15:0] t; logic [4:0] f; } load_t;
    typedef struct { int slot; logic [15:0] t; } miss_t;
    typedef struct { logic [N-1:0] busy; int fc; } st_t;

    load_t load_q[$];
    miss_t miss_q[$];
    st_t   st_q[$];
    int    vectors = 0, errors = 0, miss_seen = 0;

    bit          m_busy[N];
    logic [15:0] m_time[N];
    int          m_ptr = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lateness of a note in ticks, read as a signed 16-bit quantity.
    function automatic int late_by(logic [15:0] now, logic [15:0] t);
        int d;
        d = int'(now) - int'(t);
        if (d < 0) d += 65536;
        if (d >= 32768) d -= 65536;
        return d;
    endfunction

    // Outcome of the next clock edge given the inputs currently driven.
    task automatic model_step();
        st_t s; load_t l; miss_t ms;
        int pick = -1;
        bit full = 1'b1;
        int p;
        if (!rst_n) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ptr = 0;
        end else begin
            foreach (m_busy[i]) if (!m_busy[i]) full = 1'b0;
            if (note_valid && !full)
                for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) pick = i;
            p = m_ptr;
            if (m_busy[p] && !match_trigger[p] && late_by(song_time, m_time[p]) > 8) begin
                ms.slot = p; ms.t = m_time[p];
                miss_q.push_back(ms);
                m_busy[p] = 1'b0;
            end
            for (int i = 0; i < N; i++) if (match_trigger[i]) m_busy[i] = 1'b0;
            if (pick >= 0) begin
                m_busy[pick] = 1'b1; m_time[pick] = note_time;
                l.idx = pick; l.t = note_time; l.f = note_fret;
                load_q.push_back(l);
            end
            m_ptr = (p + 1) % N;
        end
        s.busy = '0; s.fc = N;
        for (int i = 0; i < N; i++) if (m_busy[i]) begin s.busy[i] = 1'b1; s.fc--; end
        st_q.push_back(s);
    endtask

    // Inputs are set by the caller just after a falling edge; one call = one cycle.
    task automatic tick();
        bit full = 1'b1;
        #1;
        foreach (m_busy[i]) if (!m_busy[i]) full = 1'b0;
        chk("note_ready", 64'(note_ready), 64'(rst_n && !full));
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        note_valid = 1'b0;
        match_trigger = '0;
    endtask

    task automatic do_reset(int n);
        idle();
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic send(logic [15:0] t);
        note_valid = 1'b1;
        note_time = t;
        note_fret = 5'($urandom);
        tick();
        note_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents state or events.
    initial forever begin
        st_t s; load_t l; miss_t ms;
        logic [N-1:0] oh;
        @(posedge clk);
        #2;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("slot_busy", 64'(slot_busy), 64'(s.busy));
            chk("free_count", 64'(free_count), 64'(s.fc));
            if (slot_load !== '0) begin
                if (load_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL slot_load_unexpected: got %0h expected none", slot_load);
                end else begin
                    l = load_q.pop_front();
                    oh = '0; oh[l.idx] = 1'b1;
                    chk("slot_load", 64'(slot_load), 64'(oh));
                    chk("slot_time", 64'(slot_time), 64'(l.t));
                    chk("slot_fret", 64'(slot_fret), 64'(l.f));
                end
            end
            if (miss_en !== 1'b0) begin
                miss_seen++;
                if (miss_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL miss_unexpected: got slot %0d expected none", miss_slot);
                end else begin
                    ms = miss_q.pop_front();
                    chk("miss_slot", 64'(miss_slot), 64'(ms.slot));
                    chk("miss_time", 64'(miss_time), 64'(ms.t));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        @(negedge clk);

        // Reset values
        do_reset(2);
        chk("rst_slot_load", 64'(slot_load), 64'd0);
        chk("rst_slot_time", 64'(slot_time), 64'd0);
        chk("rst_slot_fret", 64'(slot_fret), 64'd0);
        chk("rst_miss_en", 64'(miss_en), 64'd0);
        chk("rst_miss_slot", 64'(miss_slot), 64'd0);
        chk("rst_miss_time", 64'(miss_time), 64'd0);
        chk("rst_free_count", 64'(free_count), 64'd37);

        // Three back-to-back notes, then fill and free slot 12
        song_time = 16'd100;
        send(16'd100); send(16'd101); send(16'd102);
        chk("free_after_3", 64'(free_count), 64'd34);
        note_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            note_time = 16'(103 + i);
            note_fret = 5'($urandom);
            tick();
        end
        chk("full_not_ready", 64'(note_ready), 64'd0);
        note_time = 16'd500;
        repeat (2) tick();
        match_trigger[12] = 1'b1;
        tick();
        match_trigger = '0;
        repeat (2) tick();
        chk("refill_slot12", 64'(slot_busy[12]), 64'd1);
        note_valid = 1'b0;

        // Miss window boundary
        do_reset(1);
        song_time = 16'd7;
        send(16'd7);
        song_time = 16'd15;
        base = miss_seen;
        repeat (40) tick();
        chk("no_miss_at_window", 64'(miss_seen - base), 64'd0);
        song_time = 16'd16;
        repeat (38) tick();
        chk("miss_past_window", 64'(miss_seen - base), 64'd1);
        chk("miss_frees_slot0", 64'(slot_busy[0]), 64'd0);

        // Match beats miss on the scanned slot
        do_reset(1);
        song_time = 16'd0;
        send(16'd0);
        for (int g = 0; g < N && m_ptr != 0; g++) tick();
        song_time = 16'd100;
        match_trigger[0] = 1'b1;
        base = miss_seen;
        tick();
        match_trigger = '0;
        repeat (40) tick();
        chk("match_beats_miss", 64'(miss_seen - base), 64'd0);
        chk("match_frees_slot0", 64'(slot_busy[0]), 64'd0);

        // Wrap-safe lateness
        do_reset(1);
        song_time = 16'hFFF0;
        send(16'hFFFC);
        song_time = 16'h0003;
        base = miss_seen;
        repeat (40) tick();
        chk("wrap_no_miss", 64'(miss_seen - base), 64'd0);
        song_time = 16'h0005;
        repeat (38) tick();
        chk("wrap_miss", 64'(miss_seen - base), 64'd1);

        // Mid-run reset with 20 busy, overdue slots
        do_reset(1);
        song_time = 16'd200;
        note_valid = 1'b1;
        note_time = 16'd200;
        repeat (20) tick();
        note_valid = 1'b0;
        chk("pre_reset_free", 64'(free_count), 64'd17);
        song_time = 16'd1000;
        base = miss_seen;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("reset_busy", 64'(slot_busy), 64'd0);
        chk("reset_free", 64'(free_count), 64'd37);
        chk("reset_no_miss", 64'(miss_seen - base), 64'd0);

        // Randomized traffic across a song_time wrap
        song_time = 16'hFF00;
        for (int c = 0; c < 3000; c++) begin
            song_time = song_time + 16'($urandom_range(0, 2));
            rst_n = ($urandom_range(0, 499) != 0);
            note_valid = ($urandom_range(0, 9) < 7);
            note_time = song_time + 16'($urandom_range(0, 40)) - 16'd20;
            note_fret = 5'($urandom);
            for (int i = 0; i < N; i++) match_trigger[i] = ($urandom_range(0, 31) == 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        repeat (3) tick();
        #10;
        chk("load_q_drained", 64'(load_q.size()), 64'd0);
        chk("miss_q_drained", 64'(miss_q.size()), 64'd0);
        chk("st_q_drained", 64'(st_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
